// File: rtl/mul256_arb_pkg.sv
// Shared types and widths for the mul256 arbiter/sequencer.
package mul256_arb_pkg;
  localparam int OP_W   = 256;
  localparam int PROD_W = 512;
  localparam int TMO_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;
endpackage

// File: rtl/mul256_arb_rr_pick.sv
// Combinational round-robin picker: first requester above i_last, wrapping.
module mul256_arb_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_last,
  output logic [NREQ-1:0] o_grant,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    // k = NREQ revisits i_last itself, so a lone repeat requester still wins
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(i_last) + k) % NREQ;
      if (!o_any && i_req[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/mul256_arb.sv
// Round-robin sharing of one mul256 among NREQ requesters.
// Optional watchdog in WAIT enabled by defining MUL256_ARB_TIMEOUT_EN.
module mul256_arb
  import mul256_arb_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*OP_W-1:0]   req_a,
  input  logic [NREQ*OP_W-1:0]   req_b,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [PROD_W-1:0]      rsp_c,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [OP_W-1:0]        mul_a,
  output logic [OP_W-1:0]        mul_b,
  output logic                   mul_start,
  input  logic [PROD_W-1:0]      mul_c,
  input  logic                   mul_done
);

  localparam int IDXW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TMO_W)) begin : g_bad_cfg
    $error("mul256_arb: unsupported NREQ or TIMEOUT_CYCLES");
  end

  state_t              r_state;
  logic [IDXW-1:0]     r_owner;
  logic [IDXW-1:0]     r_last;
  logic [NREQ-1:0]     r_ack;
  logic [NREQ-1:0]     r_rsp_valid;
  logic [PROD_W-1:0]   r_rsp_c;
  logic                r_busy;
  logic                r_mul_start;
  logic [OP_W-1:0]     r_mul_a;
  logic [OP_W-1:0]     r_mul_b;

  logic [NREQ-1:0]     w_grant;
  logic [IDXW-1:0]     w_idx;
  logic                w_any;

  mul256_arb_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .i_req   (req),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

`ifdef MUL256_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_rsp_err;
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_last      <= IDXW'(NREQ - 1);
      r_ack       <= '0;
      r_rsp_valid <= '0;
      r_rsp_c     <= '0;
      r_busy      <= 1'b0;
      r_mul_start <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
`ifdef MUL256_ARB_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      // Strobes are one-cycle by default; states below raise them for a cycle.
      r_ack       <= '0;
      r_rsp_valid <= '0;
      r_mul_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_mul_a     <= req_a[OP_W*int'(w_idx) +: OP_W];
            r_mul_b     <= req_b[OP_W*int'(w_idx) +: OP_W];
            r_owner     <= w_idx;
            r_ack       <= w_grant;
            r_mul_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= LAUNCH;
          end
        end
        LAUNCH: begin
`ifdef MUL256_ARB_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
          r_state <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            r_rsp_c     <= mul_c;
            r_rsp_valid <= NREQ'(1) << r_owner;
            r_state     <= RESP;
          end
`ifdef MUL256_ARB_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES)) begin
            r_rsp_c     <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= NREQ'(1) << r_owner;
            r_state     <= RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          r_rsp_c <= '0;
`ifdef MUL256_ARB_TIMEOUT_EN
          r_rsp_err <= 1'b0;
`endif
          r_last  <= r_owner;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign rsp_valid = r_rsp_valid;
  assign rsp_c     = r_rsp_c;
  assign busy      = r_busy;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_start = r_mul_start;

endmodule

// File: doc/mul256_arb.md
# mul256_arb

Round-robin arbiter and sequencer that shares one `mul256` multiplier instance among NREQ requesters (e.g. SM2 point-add, point-double, and modular-inverse engines). It accepts one request at a time, latches the operands, and drives the multiplier's start/operand interface. It then waits for `done` and returns the 512-bit product to the granted requester with a one-cycle response strobe.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT (used only with MUL256_ARB_TIMEOUT_EN)
- clk  in  1  single clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester request level
- req_a  in  NREQ*256  operand A, requester i at bits [256*i+255:256*i]
- req_b  in  NREQ*256  operand B, same packing
- ack  out  NREQ  one-hot, one-cycle: request i accepted, operands captured
- rsp_valid  out  NREQ  one-hot, one-cycle: product for requester i on rsp_c
- rsp_c  out  512  product, valid only while any rsp_valid is high
- rsp_err  out  1  qualifies rsp_valid: watchdog abort, rsp_c = 0
- busy  out  1  high in every state except IDLE
- mul_a, mul_b  out  256  operands to mul256, held stable from LAUNCH through WAIT
- mul_start  out  1  one-cycle start pulse to mul256
- mul_c  in  512  mul256 product
- mul_done  in  1  mul256 completion strobe

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP. All outputs are registered.
- IDLE:
  - If any req bit is high, select winner w by round-robin: search from (last+1) mod NREQ upward with wrap.
  - Latch req_a/req_b of w into the operand registers, set owner=w, and go to LAUNCH.
  - If no req bit is high, stay in IDLE.
- LAUNCH (exactly 1 cycle):
  - ack[owner]=1 and mul_start=1.
  - Go to WAIT.
  - mul_done and req are ignored in this state.
- WAIT:
  - On mul_done=1, capture mul_c into the result register and go to RESP.
  - Any change to req or req_a/req_b has no effect.
- RESP (exactly 1 cycle):
  - rsp_valid[owner]=1 and rsp_c = result register.
  - Set last=owner and go to IDLE.
- Requester rules:
  - Hold req and operands stable until ack.
  - Dropping req before ack withdraws the request without penalty.
  - req still high in the ack cycle is not re-sampled.
  - A requester may re-request immediately after ack; the new request competes in the next IDLE.
- mul_done outside WAIT is ignored.
- Fairness: every pending requester is served within NREQ-1 other transactions.
- Reset (any time, including mid-operation):
  - state=IDLE, last=NREQ-1 (requester 0 wins first).
  - ack=0, rsp_valid=0, rsp_err=0, busy=0, mul_start=0, mul_a=mul_b=0, rsp_c=0.
  - mul256 shares rstn, so any in-flight multiply is discarded.

## Timing
- Request seen in IDLE at edge k:
  - ack and mul_start high during cycle k+1 (LAUNCH).
  - WAIT from edge k+2.
- mul_done high at edge m: rsp_valid high in cycle m+1.
- Overhead beyond multiplier latency L: 3 cycles (IDLE sample, LAUNCH, RESP). Back-to-back transactions take L+3 cycles each.
- ack and rsp_valid for the same owner are never high in the same cycle.

## Configuration
- MUL256_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no mul_done, go to RESP with rsp_err=1 and rsp_c=0.
  - A mul_done arriving after the abort is ignored.
- MUL256_ARB_TIMEOUT_EN not defined:
  - No counter; WAIT is left only on mul_done.
  - rsp_err is tied to 0; the port stays present.

## Structure
- Package mul256_arb_pkg:
  - State enum (IDLE, LAUNCH, WAIT, RESP).
  - OP_W=256, PROD_W=512, and the timeout counter width.
- Sub-module mul256_arb_rr_pick: combinational round-robin picker (req, last → one-hot grant + index), instantiated once.

## Test plan
- Single request:
  - Stimulus: req[0]=1 with a=0x3, b=0x5 (zero-extended).
  - Required: ack[0] one cycle later, with mul_start in the same cycle; rsp_valid[0] one cycle after mul_done with rsp_c=0xF; busy low after RESP.
- Max operands:
  - Stimulus: req[2] with a=b=2^256-1.
  - Required: rsp_c = 2^512 - 2^257 + 1; matches $random-based reference product for 100 random pairs.
- Contention after reset:
  - Stimulus: req=4'b1111 held.
  - Required: grant order 0,1,2,3,0; each rsp_valid one-hot, matching the owner of the preceding ack.
- Wrap and skip:
  - Stimulus: last=2, req=4'b0011.
  - Required: next grant is 0, then 1; requester 3 is never acked.
- Reset mid-WAIT:
  - Stimulus: rstn low for 2 cycles during WAIT.
  - Required: all outputs 0 immediately (async), no rsp_valid afterwards; next request after reset goes to requester 0.
- Timeout (MUL256_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mul_done forced low):
  - Required: rsp_valid with rsp_err=1 and rsp_c=0 at WAIT-entry+9; a late mul_done is ignored.
